// File: rtl/ex_alu_branch_unit_if.sv
// Execute-stage bundle: ALU operands/results, PC incrementer, branch inputs
// and the registered EX/MEM copies.
interface ex_alu_branch_unit_if #(
  parameter int WIDTH = 32
);
  logic             le;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_z;
  logic             alu_n;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] pc_plus8;
  logic             b_instr;
  logic [5:0]       opcode;
  logic [4:0]       rt;
  logic             cond_taken;
  logic [WIDTH-1:0] alu_out_r;
  logic [1:0]       flags_r;
  logic             cond_taken_r;

  modport master (
    output le, alu_op, a, b, pc_in, b_instr, opcode, rt,
    input  alu_out, alu_z, alu_n, pc_plus4, pc_plus8, cond_taken,
           alu_out_r, flags_r, cond_taken_r
  );

  modport slave (
    input  le, alu_op, a, b, pc_in, b_instr, opcode, rt,
    output alu_out, alu_z, alu_n, pc_plus4, pc_plus8, cond_taken,
           alu_out_r, flags_r, cond_taken_r
  );
endinterface

// File: rtl/ex_alu_branch_unit.sv
// EX-stage ALU, PC+4/PC+8 incrementer and branch condition resolution,
// with a load-enabled registered copy for the EX/MEM boundary.
module ex_alu_branch_unit #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  ex_alu_branch_unit_if.slave   bus
);
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  logic [WIDTH-1:0] alu_res;
  logic [4:0]       shamt;
  logic             cond;

  logic [WIDTH-1:0] alu_out_r_d, alu_out_r_q;
  logic [1:0]       flags_r_d, flags_r_q;
  logic             cond_taken_r_d, cond_taken_r_q;

  assign shamt = bus.a[4:0];

  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      4'b0000: alu_res = bus.a + bus.b;
      4'b0001: alu_res = bus.a - bus.b;
      4'b0010: alu_res = bus.a & bus.b;
      4'b0011: alu_res = bus.a | bus.b;
      4'b0100: alu_res = bus.a ^ bus.b;
      4'b0101: alu_res = ~(bus.a | bus.b);
      4'b0110: alu_res = bus.b << shamt;
      4'b0111: alu_res = bus.b >> shamt;
      4'b1000: alu_res = $signed(bus.b) >>> shamt;
      4'b1001: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b1010: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      4'b1011: alu_res = bus.a;
      4'b1100: alu_res = bus.b;
      default: alu_res = '0;
    endcase
  end

  assign bus.alu_out = alu_res;
  assign bus.alu_z   = (alu_res == '0);
  assign bus.alu_n   = alu_res[WIDTH-1];

  // Incrementer depends only on pc_in so an unknown alu_op cannot reach it.
  assign bus.pc_plus4 = bus.pc_in + WIDTH'(4);
  assign bus.pc_plus8 = bus.pc_in + WIDTH'(8);

  // Flags come from a - b; for REGIMM only rt[0] picks LTZ vs GEZ once the
  // link bit (rt[4]) and the reserved middle bits are screened.
  always_comb begin
    cond = 1'b0;
    case (bus.opcode)
      OP_BEQ:  cond = bus.alu_z;
      OP_BNE:  cond = !bus.alu_z;
      OP_BLEZ: cond = bus.alu_z | bus.alu_n;
      OP_BGTZ: cond = !bus.alu_z & !bus.alu_n;
      OP_REGIMM: begin
        if (bus.rt[3:1] == 3'b000)
          cond = bus.rt[0] ? !bus.alu_n : bus.alu_n;
      end
      default: cond = 1'b0;
    endcase
  end

  assign bus.cond_taken = bus.b_instr & cond;

  always_comb begin
    alu_out_r_d    = alu_out_r_q;
    flags_r_d      = flags_r_q;
    cond_taken_r_d = cond_taken_r_q;
    if (bus.le) begin
      alu_out_r_d    = alu_res;
      flags_r_d      = {bus.alu_z, bus.alu_n};
      cond_taken_r_d = bus.cond_taken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_out_r_q    <= '0;
      flags_r_q      <= 2'b00;
      cond_taken_r_q <= 1'b0;
    end else begin
      alu_out_r_q    <= alu_out_r_d;
      flags_r_q      <= flags_r_d;
      cond_taken_r_q <= cond_taken_r_d;
    end
  end

  assign bus.alu_out_r    = alu_out_r_q;
  assign bus.flags_r      = flags_r_q;
  assign bus.cond_taken_r = cond_taken_r_q;
endmodule

// File: tb/tb_ex_alu_branch_unit.sv
// Directed-vector bench for ex_alu_branch_unit: ALU ops, incrementer wrap,
// branch decisions and the load-enabled/reset behaviour of the output registers.
module tb_ex_alu_branch_unit;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  ex_alu_branch_unit_if #(.WIDTH(32)) bus ();

  ex_alu_branch_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input logic exp_z, input logic exp_n);
    bus.alu_op = op;
    bus.a      = a;
    bus.b      = b;
    #1;
    check(tag, bus.alu_out, exp);
    check({tag, "_z"}, {31'd0, bus.alu_z}, {31'd0, exp_z});
    check({tag, "_n"}, {31'd0, bus.alu_n}, {31'd0, exp_n});
  endtask

  task automatic run_br(input string tag, input logic bi, input logic [5:0] opc,
                        input logic [4:0] rt, input logic [31:0] a,
                        input logic [31:0] b, input logic exp_taken);
    bus.alu_op  = 4'b0001;
    bus.b_instr = bi;
    bus.opcode  = opc;
    bus.rt      = rt;
    bus.a       = a;
    bus.b       = b;
    #1;
    check(tag, {31'd0, bus.cond_taken}, {31'd0, exp_taken});
  endtask

  task automatic run_pc(input string tag, input logic [31:0] pc,
                        input logic [31:0] exp4, input logic [31:0] exp8);
    bus.pc_in = pc;
    #1;
    check({tag, "_p4"}, bus.pc_plus4, exp4);
    check({tag, "_p8"}, bus.pc_plus8, exp8);
  endtask

  task automatic check_regs(input string tag, input logic [31:0] exp_alu,
                            input logic [1:0] exp_flags, input logic exp_ct);
    check({tag, "_alu"},   bus.alu_out_r, exp_alu);
    check({tag, "_flags"}, {30'd0, bus.flags_r}, {30'd0, exp_flags});
    check({tag, "_ct"},    {31'd0, bus.cond_taken_r}, {31'd0, exp_ct});
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    bus.le      = 1'b0;
    bus.alu_op  = 4'b0000;
    bus.a       = '0;
    bus.b       = '0;
    bus.pc_in   = '0;
    bus.b_instr = 1'b0;
    bus.opcode  = 6'd0;
    bus.rt      = 5'd0;
    #1;
    check_regs("reset_init", 32'h0, 2'b00, 1'b0);

    // ALU: arithmetic and wrap
    run_alu("add_wrap",  4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
    run_alu("sub_zero",  4'b0001, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
    run_alu("sub_neg",   4'b0001, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    // logic
    run_alu("and", 4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b1);
    run_alu("or",  4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b1);
    run_alu("xor", 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0);
    run_alu("nor", 4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0);
    // shifts (only a[4:0] counts: 0x24 shifts by 4)
    run_alu("sll", 4'b0110, 32'd4, 32'h8000_0001, 32'h0000_0010, 1'b0, 1'b0);
    run_alu("srl", 4'b0111, 32'd4, 32'h8000_0001, 32'h0800_0000, 1'b0, 1'b0);
    run_alu("sra", 4'b1000, 32'd4, 32'h8000_0001, 32'hF800_0000, 1'b0, 1'b1);
    run_alu("sll_amt5", 4'b0110, 32'h24, 32'h8000_0001, 32'h0000_0010, 1'b0, 1'b0);
    // compares and passes
    run_alu("slt",  4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    run_alu("sltu", 4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    run_alu("pass_a", 4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 1'b0, 1'b0);
    run_alu("pass_b", 4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 32'h9ABC_DEF0, 1'b0, 1'b1);
    run_alu("op1101", 4'b1101, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1, 1'b0);
    run_alu("op1111", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1, 1'b0);

    // incrementer, including an unknown alu_op
    run_pc("pc0",    32'h0, 32'h4, 32'h8);
    run_pc("pcwrap", 32'hFFFF_FFFC, 32'h0, 32'h4);
    bus.alu_op = 4'bxxxx;
    run_pc("pc_xop", 32'h0000_1000, 32'h0000_1004, 32'h0000_1008);

    // branches via subtract
    run_br("bgtz_t",   1'b1, 6'b000111, 5'd0, 32'd3, 32'd0, 1'b1);
    run_br("bgtz_nt",  1'b1, 6'b000111, 5'd0, 32'd0, 32'd0, 1'b0);
    run_br("beq_t",    1'b1, 6'b000100, 5'd0, 32'd7, 32'd7, 1'b1);
    run_br("bne_nt",   1'b1, 6'b000101, 5'd0, 32'd7, 32'd7, 1'b0);
    run_br("bne_t",    1'b1, 6'b000101, 5'd0, 32'd7, 32'd6, 1'b1);
    run_br("blez_t",   1'b1, 6'b000110, 5'd0, 32'd0, 32'd0, 1'b1);
    run_br("blez_nt",  1'b1, 6'b000110, 5'd0, 32'd4, 32'd0, 1'b0);
    run_br("bltz_t",   1'b1, 6'b000001, 5'b00000, 32'hFFFF_FFFE, 32'd0, 1'b1);
    run_br("bgez_nt",  1'b1, 6'b000001, 5'b00001, 32'hFFFF_FFFE, 32'd0, 1'b0);
    run_br("bltzal_t", 1'b1, 6'b000001, 5'b10000, 32'hFFFF_FFFE, 32'd0, 1'b1);
    run_br("bgezal_t", 1'b1, 6'b000001, 5'b10001, 32'd5, 32'd0, 1'b1);
    run_br("regimm_rsv", 1'b1, 6'b000001, 5'b00010, 32'hFFFF_FFFE, 32'd0, 1'b0);
    run_br("op_other", 1'b1, 6'b000000, 5'd0, 32'd7, 32'd7, 1'b0);
    run_br("beq_nobi", 1'b0, 6'b000100, 5'd0, 32'd7, 32'd7, 1'b0);

    // registers: release reset, load add result
    @(negedge clk);
    reset       = 1'b0;
    bus.le      = 1'b1;
    bus.alu_op  = 4'b0000;
    bus.a       = 32'd2;
    bus.b       = 32'd3;
    bus.b_instr = 1'b0;
    @(posedge clk); #1;
    check_regs("load_add", 32'd5, 2'b00, 1'b0);

    // stall holds
    @(negedge clk);
    bus.le = 1'b0;
    bus.a  = 32'd10;
    bus.alu_op = 4'b0001;
    @(posedge clk); #1;
    check_regs("hold", 32'd5, 2'b00, 1'b0);

    // capture a taken BEQ with zero flag
    @(negedge clk);
    bus.le      = 1'b1;
    bus.alu_op  = 4'b0001;
    bus.a       = 32'd9;
    bus.b       = 32'd9;
    bus.b_instr = 1'b1;
    bus.opcode  = 6'b000100;
    @(posedge clk); #1;
    check_regs("load_beq", 32'd0, 2'b10, 1'b1);

    // capture negative flag
    @(negedge clk);
    bus.a = 32'd1;
    bus.b = 32'd2;
    @(posedge clk); #1;
    check_regs("load_neg", 32'hFFFF_FFFF, 2'b01, 1'b0);

    // asynchronous reset between edges, with le still high
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_regs("async_rst", 32'h0, 2'b00, 1'b0);
    check("rst_comb", bus.alu_out, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check_regs("rst_held", 32'h0, 2'b00, 1'b0);

    // first capture after release
    @(negedge clk);
    reset      = 1'b0;
    bus.alu_op = 4'b0000;
    bus.a      = 32'h8000_0000;
    bus.b      = 32'h0000_0010;
    bus.b_instr = 1'b0;
    #1;
    check_regs("post_rel", 32'h0, 2'b00, 1'b0);
    @(posedge clk); #1;
    check_regs("first_cap", 32'h8000_0010, 2'b01, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
